// File: rtl/midi_message_tx_if.sv
// Message posting port for midi_message_tx: one whole MIDI message per handshake.
// Latency: none, this is a plain signal bundle.
// Backpressure: the producer holds msg_valid and the message until msg_ready is seen high on a clock edge.
interface midi_message_tx_if;
   logic       msg_valid;
   logic       msg_ready;
   logic [7:0] status;
   logic [6:0] data1;
   logic [6:0] data2;

   modport master (output msg_valid, status, data1, data2, input msg_ready);
   modport slave  (input msg_valid, status, data1, data2, output msg_ready);
endinterface

// File: rtl/midi_message_tx.sv
// MIDI OUT transmitter: message FIFO feeding a gap-free 8N1 serializer with optional running status.
// Latency: message accepted at edge N into an idle block puts the start bit on MIDI_TX from edge N+2.
// Backpressure: msg_ready is low while the message FIFO is full; it never depends on msg_valid.
module midi_message_tx #(
   parameter int CLK_HZ         = 50000000,
   parameter int BAUD           = 31250,
   parameter int FIFO_DEPTH     = 4,
   parameter bit RUNNING_STATUS = 1'b1
) (
   input  logic             CLOCK_50,
   input  logic             rst_n,
   midi_message_tx_if.slave msg,
   output logic             MIDI_TX,
   output logic             busy,
   output logic             err
);
   localparam int BIT_TICKS = CLK_HZ / BAUD;
   localparam int TW        = $clog2(BIT_TICKS);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q;
   logic [TW-1:0] tick_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic [6:0]    byte1_q;
   logic [6:0]    byte2_q;
   logic [1:0]    rem_q;
   logic [7:0]    last_q;
   logic          tx_q;
   logic          busy_q;
   logic          err_q;
   logic          ready_q;

   // Message storage: {status, data1, data2} per entry.
   logic [21:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;

   logic tick_last, push, pop;
   logic [7:0] pop_st;
   logic [6:0] pop_d1, pop_d2;
   logic pop_len3, pop_len2, pop_skip;

   assign tick_last = (tick_q == TICK_LAST);
   // Messages with a clear status MSB are dropped at the door and only flagged.
   assign push = msg.msg_valid && ready_q && msg.status[7];
   // A message leaves the FIFO when the serializer is idle, or on the last stop-bit cycle of the previous message.
   assign pop  = (cnt_q != '0) &&
                 ((state_q == IDLE) || ((state_q == STOP) && tick_last && (rem_q == 2'd0)));

   assign {pop_st, pop_d1, pop_d2} = mem_q[rptr_q];
   assign pop_len3 = (pop_st[7:6] == 2'b10) || (pop_st[7:4] == 4'hE);
   assign pop_len2 = (pop_st[7:5] == 3'b110);
   // Skip is decided against last_status as it stands at pop time, not at accept time.
   assign pop_skip = RUNNING_STATUS && (pop_st[7:4] != 4'hF) && (pop_st == last_q);

   assign msg.msg_ready = ready_q;
   assign MIDI_TX       = tx_q;
   assign busy          = busy_q;
   assign err           = err_q;

   // Occupancy next-state: a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Message payload storage; contents are don't-care until written.
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         mem_q[wptr_q] <= {msg.status, msg.data1, msg.data2};
      end
   end

   // FIFO pointers, count and the registered not-full flag.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_ONE;
         if (pop)  rptr_q <= rptr_q + PTR_ONE;
         cnt_q   <= cnt_d;
         ready_q <= (cnt_d != CNT_FULL);
      end
   end

   // Serializer FSM with running-status tracking; the line register follows the state one cycle later.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         byte1_q <= 7'h00;
         byte2_q <= 7'h00;
         rem_q   <= 2'd0;
         last_q  <= 8'h00;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         tx_q   <= (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
         busy_q <= (state_q != IDLE) || (cnt_q != '0);
         err_q  <= msg.msg_valid && ready_q && !msg.status[7];

         if (pop) begin
            if (pop_skip) begin
               shift_q <= {1'b0, pop_d1};
               byte1_q <= pop_d2;
               rem_q   <= pop_len3 ? 2'd1 : 2'd0;
            end else begin
               shift_q <= pop_st;
               byte1_q <= pop_d1;
               byte2_q <= pop_d2;
               rem_q   <= pop_len3 ? 2'd2 : (pop_len2 ? 2'd1 : 2'd0);
            end
            // Channel messages become the running status; system common clears it; real-time keeps it.
            if (pop_st[7:4] != 4'hF) begin
               last_q <= pop_st;
            end else if (!pop_st[3]) begin
               last_q <= 8'h00;
            end
         end

         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q <= START;
                  tick_q  <= '0;
               end
            end
            START: begin
               if (tick_last) begin
                  tick_q  <= '0;
                  bit_q   <= 3'd0;
                  state_q <= DATA;
               end else begin
                  tick_q <= tick_q + TICK_ONE;
               end
            end
            DATA: begin
               if (tick_last) begin
                  tick_q  <= '0;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end else begin
                  tick_q <= tick_q + TICK_ONE;
               end
            end
            STOP: begin
               if (tick_last) begin
                  tick_q <= '0;
                  if (rem_q != 2'd0) begin
                     shift_q <= {1'b0, byte1_q};
                     byte1_q <= byte2_q;
                     rem_q   <= rem_q - 2'd1;
                     state_q <= START;
                  end else if (pop) begin
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  tick_q <= tick_q + TICK_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
